core_sequencer: RTL and testbench

Instruction issue controller for the 16-bit `Core`. It accepts instructions from a host over a valid/ready stream and buffers them in a small FIFO. It issues at most one instruction per cycle to `Core` and captures the resulting `reg_dump` write-back record into a 2-entry result buffer. Back-pressure from the result consumer stalls issue, so no write-back record is ever lost.

---
 rtl/core_seq_pkg.sv | 15 +
 rtl/seq_fifo.sv | 76 +++++++
 rtl/core_sequencer.sv | 118 +++++++++++
 tb/tb_core_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_seq_pkg.sv
// Shared types and sizes for the core_sequencer issue controller.
package core_seq_pkg;

   localparam int INSTR_W   = 16;   // Core instruction width
   localparam int DUMP_W    = 20;   // Core write-back record {data[15:0], rd[3:0]}
   localparam int RES_DEPTH = 2;    // result buffer entries (also the issue credit limit)

   // Opcode field of a Core instruction, instr[15:12].
   typedef enum logic [3:0] {
      OP_ADD  = 4'h1,
      OP_SUB  = 4'h2,
      OP_ADDI = 4'h9
   } opcode_t;

endpackage

// File: rtl/seq_fifo.sv
// Synchronous first-word fall-through FIFO. The head is visible on dout
// whenever the FIFO is non-empty and reads as zero when it is empty.
// Push while full is accepted only if a pop happens in the same cycle.
module seq_fifo #(
   parameter int  WIDTH = 16,
   parameter int  DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign dout  = empty ? '0 : mem_q[rd_ptr_q];

   // Next-state for storage, pointers and occupancy.
   always_comb begin
      // NOTE: every signal gets a default before any condition so no latch is inferred.
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Control state register with synchronous active-low reset.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array update.
   always_ff @(posedge clock) begin
      // NOTE: storage is not reset; empty masks dout, so stale entries are never observed.
      mem_q <= mem_d;
   end

endmodule

// File: rtl/core_sequencer.sv
// Instruction issue controller for the 16-bit Core. Buffers host
// instructions, issues at most one per cycle under a 2-record credit, and
// captures each Core write-back record into a 2-entry result FIFO.
// Optional perf counters are compiled in with `define CORE_SEQ_PERF_EN.
module core_sequencer
   import core_seq_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               in_valid,
   input  logic [INSTR_W-1:0] in_instr,
   output logic               in_ready,
   output logic               core_instr_valid,
   output logic [INSTR_W-1:0] core_instr,
   input  logic [DUMP_W-1:0]  core_reg_dump,
   output logic               out_valid,
   output logic [DUMP_W-1:0]  out_data,
   input  logic               out_ready,
`ifdef CORE_SEQ_PERF_EN
   output logic [15:0]        perf_issued,
   output logic [15:0]        perf_stall,
`endif
   output logic               busy
);

   localparam int ICW = $clog2(DEPTH + 1);
   localparam int RCW = $clog2(RES_DEPTH + 1);

   logic               ififo_full, ififo_empty;
   logic [ICW-1:0]     ififo_count;
   logic [INSTR_W-1:0] ififo_head;
   logic               rfifo_full, rfifo_empty;
   logic [RCW-1:0]     rfifo_count;
   logic               inflight_q, inflight_d;
   logic               ipush, rpop, issue;
   logic [2:0]         credit_used;

   // Reset gates in_ready so the host cannot push while reset is held.
   assign in_ready         = reset_n && !ififo_full;
   assign ipush            = in_valid && in_ready;
   assign out_valid        = !rfifo_empty;
   assign core_instr_valid = issue;
   assign core_instr       = ififo_head;
   assign busy             = (ififo_count != '0) || inflight_q || (rfifo_count != '0);

   seq_fifo #(.WIDTH(INSTR_W), .DEPTH(DEPTH)) u_ififo (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (ipush),
      .din     (in_instr),
      .pop     (issue),
      .dout    (ififo_head),
      .full    (ififo_full),
      .empty   (ififo_empty),
      .count   (ififo_count)
   );

   seq_fifo #(.WIDTH(DUMP_W), .DEPTH(RES_DEPTH)) u_rfifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (inflight_q),
      .din     (core_reg_dump),
      .pop     (rpop),
      .dout    (out_data),
      .full    (rfifo_full),
      .empty   (rfifo_empty),
      .count   (rfifo_count)
   );

   // Credit check: records held plus the one in flight, less the one leaving now.
   always_comb begin
      rpop        = out_valid && out_ready;
      credit_used = 3'(rfifo_count) + 3'(inflight_q) - 3'(rpop);
      issue       = !ififo_empty && (credit_used < 3'(RES_DEPTH));
      inflight_d  = issue;
   end

   // In-flight flag: one cycle wide, marks the cycle whose reg_dump is captured.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         inflight_q <= 1'b0;
      end else begin
         inflight_q <= inflight_d;
      end
   end

   // The credit rule must keep the result FIFO from overflowing.
   rfifo_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
      !(inflight_q && rfifo_full && !rpop));

`ifdef CORE_SEQ_PERF_EN
   logic [15:0] perf_issued_q, perf_issued_d;
   logic [15:0] perf_stall_q, perf_stall_d;

   // Free-running wrap-around counters of issue and stall cycles.
   always_comb begin
      perf_issued_d = perf_issued_q + 16'(issue);
      perf_stall_d  = perf_stall_q + 16'(!ififo_empty && !issue);
   end

   // Perf counter registers.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         perf_issued_q <= '0;
         perf_stall_q  <= '0;
      end else begin
         perf_issued_q <= perf_issued_d;
         perf_stall_q  <= perf_stall_d;
      end
   end

   assign perf_issued = perf_issued_q;
   assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer with a small behavioural Core model.
module tb_core_sequencer;

   logic        clock;
   logic        reset_n;
   logic        in_valid;
   logic [15:0] in_instr;
   logic        in_ready;
   logic        core_instr_valid;
   logic [15:0] core_instr;
   logic [19:0] core_reg_dump;
   logic        out_valid;
   logic [19:0] out_data;
   logic        out_ready;
   logic        busy;
`ifdef CORE_SEQ_PERF_EN
   logic [15:0] perf_issued;
   logic [15:0] perf_stall;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int n_issue = 0;
   logic [19:0] got_q [$];

   core_sequencer #(.DEPTH(4)) dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .in_valid         (in_valid),
      .in_instr         (in_instr),
      .in_ready         (in_ready),
      .core_instr_valid (core_instr_valid),
      .core_instr       (core_instr),
      .core_reg_dump    (core_reg_dump),
      .out_valid        (out_valid),
      .out_data         (out_data),
      .out_ready        (out_ready),
`ifdef CORE_SEQ_PERF_EN
      .perf_issued      (perf_issued),
      .perf_stall       (perf_stall),
`endif
      .busy             (busy)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Behavioural Core: executes an issued instruction at the posedge and
   // presents {data, rd} on reg_dump for the following cycle.
   logic [15:0] regs [16];
   always @(posedge clock) begin
      if (!reset_n) begin
         for (int i = 0; i < 16; i++) regs[i] <= '0;
         core_reg_dump <= '0;
      end else if (core_instr_valid) begin
         core_reg_dump <= {core_result(core_instr), core_instr[11:8]};
         if (core_instr[11:8] != 4'd0) regs[core_instr[11:8]] <= core_result(core_instr);
      end
   end

   function automatic logic [15:0] core_result(input logic [15:0] ins);
      logic [15:0] v;
      case (ins[15:12])
         4'h1:    v = regs[ins[7:4]] + regs[ins[3:0]];
         4'h2:    v = regs[ins[7:4]] - regs[ins[3:0]];
         4'h9:    v = regs[ins[7:4]] + {12'h000, ins[3:0]};
         default: v = regs[ins[11:8]];
      endcase
      return (ins[11:8] == 4'd0) ? 16'h0000 : v;
   endfunction

   // Mid-cycle monitor: records delivered to the consumer and issue count.
   initial begin
      forever begin
         @(negedge clock);
         if (reset_n && out_valid && out_ready) got_q.push_back(out_data);
         if (reset_n && core_instr_valid) n_issue++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic apply_reset();
      reset_n  = 1'b0;
      in_valid = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      #1;
   endtask

   logic [15:0] bp_instr [6] = '{16'h9101, 16'h9202, 16'h9303, 16'h9404, 16'h9505, 16'h9606};
   logic [19:0] bp_exp   [6] = '{20'h00011, 20'h00022, 20'h00033, 20'h00044, 20'h00055, 20'h00066};
   int base;

   initial begin
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_instr  = '0;
      out_ready = 1'b1;

      // Reset state
      tick();
      tick();
      check("rst_in_ready", 32'(in_ready), 0);
      check("rst_civ", 32'(core_instr_valid), 0);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_core_instr", 32'(core_instr), 0);
      check("rst_out_data", 32'(out_data), 0);
      reset_n = 1'b1;
      #1;
      check("post_rst_in_ready", 32'(in_ready), 1);

      // Single ADDI r1,r0,5
      in_valid = 1'b1;
      in_instr = 16'h9105;
      tick();
      in_valid = 1'b0;
      #1;
      check("addi_civ", 32'(core_instr_valid), 1);
      check("addi_instr", 32'(core_instr), 32'h9105);
      check("addi_busy", 32'(busy), 1);
      tick();
      check("addi_civ_pulse", 32'(core_instr_valid), 0);
      check("addi_no_rec_yet", 32'(out_valid), 0);
      tick();
      check("addi_out_valid", 32'(out_valid), 1);
      check("addi_out_data", 32'(out_data), 32'h00051);
      tick();
      check("addi_drained", 32'(out_valid), 0);
      check("addi_idle", 32'(busy), 0);

      // Dependent stream
      apply_reset();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_instr  = 16'h9105;
      tick();
      in_instr = 16'h1211;
      tick();
      in_instr = 16'h2321;
      tick();
      in_valid = 1'b0;
      check("dep_rec0", 32'(out_data), 32'h00051);
      check("dep_rec0_v", 32'(out_valid), 1);
      tick();
      check("dep_rec1", 32'(out_data), 32'h000A2);
      tick();
      check("dep_rec2", 32'(out_data), 32'h00053);
      tick();
      check("dep_done", 32'(out_valid), 0);
`ifdef CORE_SEQ_PERF_EN
      check("dep_perf_issued", 32'(perf_issued), 3);
`endif

      // Back-pressure: consumer stalled, six pushes
      apply_reset();
      got_q.delete();
      out_ready = 1'b0;
      base = n_issue;
      for (int i = 0; i < 6; i++) begin
         check("bp_in_ready", 32'(in_ready), 1);
         in_valid = 1'b1;
         in_instr = bp_instr[i];
         tick();
      end
      in_valid = 1'b0;
      #1;
      check("bp_full", 32'(in_ready), 0);
      check("bp_civ_low", 32'(core_instr_valid), 0);
      check("bp_issues", 32'(n_issue - base), 2);
      check("bp_head", 32'(out_data), 32'h00011);
      tick();
      tick();
      tick();
      check("bp_civ_hold", 32'(core_instr_valid), 0);
      check("bp_issues_hold", 32'(n_issue - base), 2);
      out_ready = 1'b1;
      for (int c = 0; c < 40 && got_q.size() < 6; c++) tick();
      tick();
      check("bp_rec_count", 32'(got_q.size()), 6);
      for (int i = 0; i < 6 && i < got_q.size(); i++) check("bp_rec_order", 32'(got_q[i]), 32'(bp_exp[i]));
      check("bp_idle", 32'(busy), 0);

      // r0 destination
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_instr  = 16'h9003;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      check("r0_valid", 32'(out_valid), 1);
      check("r0_data", 32'(out_data), 32'h00000);
      check("r0_busy", 32'(busy), 1);
      tick();
      check("r0_idle", 32'(busy), 0);

      // Reset mid-stream
      got_q.delete();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_instr  = 16'h9101;
      tick();
      in_instr = 16'h9202;
      tick();
      in_instr = 16'h9303;
      reset_n  = 1'b0;
      tick();
      check("mid_rst_in_ready", 32'(in_ready), 0);
      check("mid_rst_out_valid", 32'(out_valid), 0);
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_civ", 32'(core_instr_valid), 0);
      reset_n  = 1'b1;
      in_valid = 1'b0;
      #1;
      check("mid_rel_in_ready", 32'(in_ready), 1);
      tick();
      tick();
      check("mid_no_stray", 32'(out_valid), 0);
      check("mid_idle", 32'(busy), 0);
      check("mid_no_records", 32'(got_q.size()), 0);

`ifdef CORE_SEQ_PERF_EN
      // Perf counters: two stall cycles, then issue-counter wrap
      apply_reset();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 16'h9101;
      tick();
      in_instr = 16'h9202;
      tick();
      in_instr = 16'h9303;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      check("perf_stall", 32'(perf_stall), 2);
      check("perf_issued_bp", 32'(perf_issued), 2);
      force dut.perf_issued_q = 16'hFFFF;
      #1;
      release dut.perf_issued_q;
      out_ready = 1'b1;
      tick();
      check("perf_wrap", 32'(perf_issued), 0);
      for (int c = 0; c < 20 && busy; c++) tick();
      check("perf_idle", 32'(busy), 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
